// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered instruction decode stage with valid/ready handshake and HALT/resume control
module decode_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int SP_REG = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       ins,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [5:0]        opcode,
    output logic [REG_AW-1:0] rs,
    output logic [REG_AW-1:0] rt,
    output logic [REG_AW-1:0] rd,
    output logic [4:0]        shamt,
    output logic [5:0]        funct,
    output logic [XLEN-1:0]   imm,
    output logic              illegal,
    output logic              halted,
    input  logic              resume
);

    localparam logic [REG_AW-1:0] SP_IDX = REG_AW'(SP_REG);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_SLAI  = 6'h07;
    localparam logic [5:0] OP_SRLI  = 6'h08;
    localparam logic [5:0] OP_SRAI  = 6'h09;
    localparam logic [5:0] OP_MOVE  = 6'h12;
    localparam logic [5:0] OP_PUSH  = 6'h13;
    localparam logic [5:0] OP_POP   = 6'h14;
    localparam logic [5:0] OP_CALL  = 6'h15;
    localparam logic [5:0] OP_HALT  = 6'h16;
    localparam logic [5:0] OP_NOP   = 6'h17;
    localparam logic [5:0] OP_RET   = 6'h18;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic              out_valid_q, out_valid_d;
    logic [5:0]        opcode_q, opcode_d;
    logic [REG_AW-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [4:0]        shamt_q, shamt_d;
    logic [5:0]        funct_q, funct_d;
    logic [XLEN-1:0]   imm_q, imm_d;
    logic              illegal_q, illegal_d;

    logic [5:0]        dec_opcode;
    logic [REG_AW-1:0] dec_rs, dec_rt, dec_rd;
    logic [4:0]        dec_shamt;
    logic [5:0]        dec_funct;
    logic [XLEN-1:0]   dec_imm;
    logic [XLEN-1:0]   sext_imm;
    logic              dec_illegal;
    logic              accept;

    always_comb begin
        dec_opcode  = ins[31:26];
        dec_rs      = '0;
        dec_rt      = '0;
        dec_rd      = '0;
        dec_shamt   = '0;
        dec_funct   = '0;
        dec_imm     = '0;
        dec_illegal = 1'b0;
        sext_imm    = {{(XLEN-16){ins[15]}}, ins[15:0]};
        case (dec_opcode)
            OP_RTYPE: begin
                dec_rs    = REG_AW'(ins[25:21]);
                dec_rt    = REG_AW'(ins[20:16]);
                dec_rd    = REG_AW'(ins[15:11]);
                dec_shamt = ins[10:6];
                dec_funct = ins[5:0];
            end
            OP_PUSH, OP_POP: begin
                dec_rs = SP_IDX;
                dec_rd = SP_IDX;
                dec_rt = REG_AW'(ins[25:21]);
            end
            OP_CALL: begin
                dec_rs  = SP_IDX;
                dec_rd  = SP_IDX;
                dec_imm = sext_imm;
            end
            OP_RET: begin
                dec_rs = SP_IDX;
                dec_rd = SP_IDX;
            end
            OP_HALT, OP_NOP: begin
                dec_illegal = 1'b0;
            end
            OP_MOVE: begin
                dec_rs = REG_AW'(ins[25:21]);
                dec_rt = REG_AW'(ins[20:16]);
            end
            default: begin
                // Remaining two-register/immediate forms: 0x01-0x0F and 0x19-0x1B
                if (dec_opcode <= 6'h0F || (dec_opcode >= 6'h19 && dec_opcode <= 6'h1B)) begin
                    dec_rs  = REG_AW'(ins[25:21]);
                    dec_rt  = REG_AW'(ins[20:16]);
                    dec_imm = sext_imm;
                    if (dec_opcode == OP_SLAI || dec_opcode == OP_SRLI || dec_opcode == OP_SRAI) begin
                        dec_shamt = ins[4:0];
                    end
                end else begin
                    dec_illegal = 1'b1;
                end
            end
        endcase
    end

    assign halted   = (state_q == ST_HALTED);
    assign in_ready = !halted && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        opcode_d    = opcode_q;
        rs_d        = rs_q;
        rt_d        = rt_q;
        rd_d        = rd_q;
        shamt_d     = shamt_q;
        funct_d     = funct_q;
        imm_d       = imm_q;
        illegal_d   = illegal_q;
        state_d     = state_q;
        if (accept) begin
            out_valid_d = 1'b1;
            opcode_d    = dec_opcode;
            rs_d        = dec_rs;
            rt_d        = dec_rt;
            rd_d        = dec_rd;
            shamt_d     = dec_shamt;
            funct_d     = dec_funct;
            imm_d       = dec_imm;
            illegal_d   = dec_illegal;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        // A resume coinciding with the HALT accept is ignored because RUN never looks at it
        if (state_q == ST_RUN) begin
            if (accept && dec_opcode == OP_HALT) begin
                state_d = ST_HALTED;
            end
        end else begin
            if (resume) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            out_valid_q <= 1'b0;
            opcode_q    <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            shamt_q     <= '0;
            funct_q     <= '0;
            imm_q       <= '0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            opcode_q    <= opcode_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            rd_q        <= rd_d;
            shamt_q     <= shamt_d;
            funct_q     <= funct_d;
            imm_q       <= imm_d;
            illegal_q   <= illegal_d;
        end
    end

    assign out_valid = out_valid_q;
    assign opcode    = opcode_q;
    assign rs        = rs_q;
    assign rt        = rt_q;
    assign rd        = rd_q;
    assign shamt     = shamt_q;
    assign funct     = funct_q;
    assign imm       = imm_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage with a spec-level reference model
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] ins = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [31:0] imm;
    logic        illegal;
    logic        halted;
    logic        resume = 1'b0;

    int errors = 0;
    int checks = 0;
    int n_accepted = 0;
    int n_delivered = 0;

    logic        m_valid = 1'b0;
    logic        m_halted = 1'b0;
    logic [64:0] m_b = '0;
    logic [64:0] act_b;

    localparam logic [31:0] HALT_INS = 32'h5800_0000;

    assign act_b = {opcode, rs, rt, rd, shamt, funct, imm, illegal};

    decode_stage #(.XLEN(32), .REG_AW(5), .SP_REG(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ins(ins),
        .out_valid(out_valid), .out_ready(out_ready), .opcode(opcode), .rs(rs), .rt(rt),
        .rd(rd), .shamt(shamt), .funct(funct), .imm(imm), .illegal(illegal),
        .halted(halted), .resume(resume)
    );

    always #5 clk = ~clk;

    // Expected bundle {opcode,rs,rt,rd,shamt,funct,imm,illegal} from the instruction-set rules
    function automatic logic [64:0] ref_decode(input logic [31:0] w);
        logic [5:0]  op;
        logic [4:0]  r_rs, r_rt, r_rd, r_sh;
        logic [5:0]  r_fn;
        logic [31:0] se, r_imm;
        logic        ill;
        op = w[31:26];
        se = w[15] ? (32'(w[15:0]) - 32'h0001_0000) : 32'(w[15:0]);
        r_rs = 0; r_rt = 0; r_rd = 0; r_sh = 0; r_fn = 0; r_imm = 0; ill = 0;
        if (op == 6'h00) begin
            r_rs = w[25:21]; r_rt = w[20:16]; r_rd = w[15:11]; r_sh = w[10:6]; r_fn = w[5:0];
        end else if (op == 6'h13 || op == 6'h14) begin
            r_rs = 5'd16; r_rd = 5'd16; r_rt = w[25:21];
        end else if (op == 6'h15) begin
            r_rs = 5'd16; r_rd = 5'd16; r_imm = se;
        end else if (op == 6'h18) begin
            r_rs = 5'd16; r_rd = 5'd16;
        end else if (op == 6'h16 || op == 6'h17) begin
            ill = 0;
        end else if (op <= 6'h0F || (op >= 6'h12 && op <= 6'h1B)) begin
            r_rs = w[25:21]; r_rt = w[20:16];
            if (op >= 6'h07 && op <= 6'h09) r_sh = w[4:0];
            r_imm = (op == 6'h12) ? 32'h0 : se;
        end else begin
            ill = 1;
        end
        return {op, r_rs, r_rt, r_rd, r_sh, r_fn, r_imm, ill};
    endfunction

    function automatic logic [31:0] rand_ins(input logic allow_halt);
        logic [31:0] w;
        logic [5:0]  ops [12];
        ops = '{6'h00, 6'h01, 6'h07, 6'h09, 6'h12, 6'h13, 6'h14, 6'h15, 6'h18, 6'h17, 6'h10, 6'h1B};
        w = $urandom;
        if ($urandom_range(0, 1) == 1) w[31:26] = ops[$urandom_range(0, 11)];
        if (!allow_halt && w[31:26] == 6'h16) w[31:26] = 6'h17;
        return w;
    endfunction

    // Drives one cycle of inputs, compares outputs to the model, then advances the model
    task automatic drive_cycle(input logic v, input logic [31:0] w, input logic r, input logic res);
        logic exp_rdy, acc;
        @(negedge clk);
        in_valid = v; ins = w; out_ready = r; resume = res;
        #1;
        exp_rdy = !m_halted && (!m_valid || r);
        checks++;
        if (out_valid !== m_valid) begin
            errors++; $display("FAIL out_valid: got %b want %b at %0t", out_valid, m_valid, $time);
        end
        if (m_valid) begin
            checks++;
            if (act_b !== m_b) begin
                errors++; $display("FAIL bundle: got %h want %h at %0t", act_b, m_b, $time);
            end
        end
        checks++;
        if (halted !== m_halted) begin
            errors++; $display("FAIL halted: got %b want %b at %0t", halted, m_halted, $time);
        end
        checks++;
        if (in_ready !== exp_rdy) begin
            errors++; $display("FAIL in_ready: got %b want %b at %0t", in_ready, exp_rdy, $time);
        end
        if (out_valid === 1'b1 && r) n_delivered++;
        acc = v && exp_rdy;
        if (acc) n_accepted++;
        if (!m_halted && acc && w[31:26] == 6'h16) m_halted = 1'b1;
        else if (m_halted && res) m_halted = 1'b0;
        if (acc) begin
            m_valid = 1'b1; m_b = ref_decode(w);
        end else if (r) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (out_valid !== 1'b0 || act_b !== 65'h0 || halted !== 1'b0) begin
            errors++; $display("FAIL reset_state: got v=%b b=%h h=%b want 0", out_valid, act_b, halted);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_valid = 1'b0; m_halted = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] words [5];
        logic [64:0] want [5];
        words = '{32'h0022_1820, 32'h0441_FFFC, 32'h2441_0003, 32'h4CA0_0000, 32'hFC00_0000};
        want[0] = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 32'h0, 1'b0};
        want[1] = {6'h01, 5'd2, 5'd1, 5'd0, 5'd0, 6'h00, 32'hFFFF_FFFC, 1'b0};
        want[2] = {6'h09, 5'd2, 5'd1, 5'd0, 5'd3, 6'h00, 32'h0000_0003, 1'b0};
        want[3] = {6'h13, 5'd16, 5'd5, 5'd16, 5'd0, 6'h00, 32'h0, 1'b0};
        want[4] = {6'h3F, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 32'h0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, words[i], 1'b1, 1'b0);
            drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
            checks++;
            if (out_valid !== 1'b1 || act_b !== want[i]) begin
                errors++;
                $display("FAIL directed_%0d: got v=%b b=%h want v=1 b=%h", i, out_valid, act_b, want[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [64:0] held;
        n_accepted = 0; n_delivered = 0;
        drive_cycle(1'b1, rand_ins(1'b0), 1'b1, 1'b0);
        drive_cycle(1'b1, rand_ins(1'b0), 1'b0, 1'b0);
        held = act_b;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, rand_ins(1'b0), 1'b0, 1'b0);
            checks++;
            if (act_b !== held || in_ready !== 1'b0) begin
                errors++; $display("FAIL stall_hold: got b=%h rdy=%b want b=%h rdy=0", act_b, in_ready, held);
            end
        end
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, rand_ins(1'b0), 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
        checks++;
        if (n_delivered != n_accepted) begin
            errors++; $display("FAIL bp_count: delivered %0d want %0d", n_delivered, n_accepted);
        end
    endtask

    task automatic test_halt();
        drive_cycle(1'b1, HALT_INS, 1'b1, 1'b1);
        drive_cycle(1'b1, rand_ins(1'b0), 1'b1, 1'b0);
        checks++;
        if (halted !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b1 || opcode !== 6'h16) begin
            errors++; $display("FAIL halt_enter: got h=%b rdy=%b v=%b op=%h want 1 0 1 16",
                               halted, in_ready, out_valid, opcode);
        end
        drive_cycle(1'b1, rand_ins(1'b0), 1'b1, 1'b0);
        drive_cycle(1'b1, rand_ins(1'b0), 1'b1, 1'b1);
        drive_cycle(1'b1, 32'h0022_1820, 1'b1, 1'b0);
        checks++;
        if (halted !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL halt_resume: got h=%b rdy=%b want 0 1", halted, in_ready);
        end
        drive_cycle(1'b0, 32'h0, 1'b1, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || rd !== 5'd3 || halted !== 1'b0) begin
            errors++; $display("FAIL halt_next: got v=%b rd=%0d h=%b want 1 3 0", out_valid, rd, halted);
        end
    endtask

    task automatic test_async_reset();
        drive_cycle(1'b1, HALT_INS, 1'b0, 1'b0);
        drive_cycle(1'b0, 32'h0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || act_b !== 65'h0 || halted !== 1'b0) begin
            errors++; $display("FAIL async_reset: got v=%b b=%h h=%b want 0", out_valid, act_b, halted);
        end
        m_valid = 1'b0; m_halted = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        drive_cycle(1'b1, 32'h0441_FFFC, 1'b1, 1'b0);
        drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        n_accepted = 0; n_delivered = 0;
        for (int i = 0; i < 400; i++) begin
            drive_cycle($urandom_range(0, 3) != 0, rand_ins(1'b1), $urandom_range(0, 2) != 0,
                        $urandom_range(0, 7) == 0);
        end
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 32'h0, 1'b1, 1'b1);
        checks++;
        if (n_delivered != n_accepted) begin
            errors++; $display("FAIL rand_count: delivered %0d want %0d", n_delivered, n_accepted);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_halt();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
